// File: rtl/mmio_data_memory_display.sv
// Word-addressed data RAM plus a memory-mapped, free-running multiplexed
// seven-segment display controller on the CPU load/store port.
module mmio_data_memory_display #(
  parameter int          RAM_WORDS  = 512,
  parameter int          ADDR_BITS  = 9,
  parameter int          NUM_DIGITS = 4,
  parameter int          SCAN_DIV   = 50000,
  parameter logic [31:0] MMIO_BASE  = 32'h4000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  input  logic [31:0]           Write_data,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  output logic [31:0]           Mem_data,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [7:0]            CATHODES
);

  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [9:0] OFF_DIGITS = 10'h004;
  localparam logic [9:0] OFF_CTRL   = 10'h005;

  // Address decode
  logic                 is_mmio;
  logic [9:0]           reg_off;
  logic [ADDR_BITS-1:0] ram_idx;
  logic                 unused_addr_bits;

  assign is_mmio          = (Address[31:12] == MMIO_BASE[31:12]);
  assign reg_off          = Address[11:2];
  assign ram_idx          = Address[ADDR_BITS+1:2];
  assign unused_addr_bits = ^Address[1:0];

  // RAM: no reset so it maps onto block/distributed memory
  logic [31:0] ram_mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (MemWrite && !is_mmio) begin
      ram_mem[ram_idx] <= Write_data;
    end
  end

  // Peripheral registers
  logic [31:0] digits_q, digits_d;
  logic        en_q, en_d;
  logic [7:0]  dp_q, dp_d;

  always_comb begin
    digits_d = digits_q;
    en_d     = en_q;
    dp_d     = dp_q;
    if (MemWrite && is_mmio) begin
      case (reg_off)
        OFF_DIGITS: digits_d = Write_data;
        OFF_CTRL: begin
          en_d = Write_data[0];
          dp_d = Write_data[15:8];
        end
        default: ;
      endcase
    end
  end

  // Load path
  always_comb begin
    Mem_data = 32'h0;
    if (MemRead) begin
      if (is_mmio) begin
        case (reg_off)
          OFF_DIGITS: Mem_data = digits_q;
          OFF_CTRL:   Mem_data = {16'h0, dp_q, 7'h0, en_q};
          default:    Mem_data = 32'h0;
        endcase
      end else begin
        Mem_data = ram_mem[ram_idx];
      end
    end
  end

  // Scanner
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            cath_q, cath_d;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic [3:0]            cur_nib;
  logic                  cur_dp;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
    assign digit_sel[gi] = (idx_q == IDX_W'(gi));
  end

  // One-hot select of the current digit's nibble and dp bit
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_sel[i]) begin
        cur_nib = cur_nib | digits_q[4*i +: 4];
        cur_dp  = cur_dp | dp_q[i];
      end
    end
  end

  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    an_d    = an_q;
    cath_d  = cath_q;
    if (!en_q) begin
      presc_d = '0;
      idx_d   = '0;
      an_d    = '1;
      cath_d  = 8'hFF;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      an_d    = ~digit_sel;
      cath_d  = {~cur_dp, seg7(cur_nib)};
      idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits_q <= 32'h0;
      en_q     <= 1'b1;
      dp_q     <= 8'h0;
      presc_q  <= '0;
      idx_q    <= '0;
      an_q     <= '1;
      cath_q   <= 8'hFF;
    end else begin
      digits_q <= digits_d;
      en_q     <= en_d;
      dp_q     <= dp_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      cath_q   <= cath_d;
    end
  end

  assign AN       = an_q;
  assign CATHODES = cath_q;

endmodule

// File: tb/tb_mmio_data_memory_display.sv
// Bench for mmio_data_memory_display: load/store vector table, then a scripted
// scan run with expected display spans, reset-mid-frame and first-tick checks.
module tb_mmio_data_memory_display;

  localparam logic [31:0] A_DIGITS = 32'h4000_0010;
  localparam logic [31:0] A_CTRL   = 32'h4000_0014;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_data;
  logic [3:0]  an;
  logic [7:0]  cath;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        re;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int         k_lo;
    int         k_hi;
    logic [3:0] an;
    logic [7:0] cath;
  } span_t;

  typedef struct {
    int          k;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [3:0] an;
    logic [7:0] cath;
  } disp_t;

  vec_t        vecs[$];
  span_t       spans[$];
  wr_t         writes[$];
  disp_t       disp_q[$];
  logic [31:0] rd_q[$];

  mmio_data_memory_display #(
    .RAM_WORDS (512),
    .ADDR_BITS (9),
    .NUM_DIGITS(4),
    .SCAN_DIV  (4),
    .MMIO_BASE (32'h4000_0000)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .Address   (addr),
    .Write_data(wdata),
    .MemRead   (mem_read),
    .MemWrite  (mem_write),
    .Mem_data  (mem_data),
    .AN        (an),
    .CATHODES  (cath)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_disp(input string name);
    disp_t e;
    e = disp_q.pop_front();
    check(name, {20'h0, an, cath}, {20'h0, e.an, e.cath});
  endtask

  function automatic disp_t exp_at(input int k);
    disp_t d;
    d.an   = 4'hF;
    d.cath = 8'hFF;
    foreach (spans[i]) begin
      if (k >= spans[i].k_lo && k <= spans[i].k_hi) begin
        d.an   = spans[i].an;
        d.cath = spans[i].cath;
      end
    end
    return d;
  endfunction

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    wdata     = d;
    mem_write = 1'b1;
    mem_read  = 1'b0;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    disp_t       d;

    vecs.push_back('{"rd_ctrl_rst",   A_CTRL,        1'b0, 32'h0,         1'b1, 32'h0000_0001});
    vecs.push_back('{"rd_digits_rst", A_DIGITS,      1'b0, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{"wr_ram_08",     32'h0000_0008, 1'b1, 32'h1234_5678, 1'b0, 32'h0});
    vecs.push_back('{"rd_ram_08",     32'h0000_0008, 1'b0, 32'h0,         1'b1, 32'h1234_5678});
    vecs.push_back('{"rd_alias_808",  32'h0000_0808, 1'b0, 32'h0,         1'b1, 32'h1234_5678});
    vecs.push_back('{"rd_disabled",   32'h0000_0008, 1'b0, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{"wr_ram_20",     32'h0000_0020, 1'b1, 32'h5A5A_5A5A, 1'b0, 32'h0});
    vecs.push_back('{"wr_unmapped",   32'h4000_0020, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0});
    vecs.push_back('{"rd_unmapped",   32'h4000_0020, 1'b0, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{"rd_ram_20",     32'h0000_0020, 1'b0, 32'h0,         1'b1, 32'h5A5A_5A5A});
    vecs.push_back('{"wr_ram_0c",     32'h0000_000C, 1'b1, 32'h1111_1111, 1'b0, 32'h0});
    vecs.push_back('{"rw_same_0c",    32'h0000_000C, 1'b1, 32'h2222_2222, 1'b1, 32'h1111_1111});
    vecs.push_back('{"rd_new_0c",     32'h0000_000C, 1'b0, 32'h0,         1'b1, 32'h2222_2222});
    vecs.push_back('{"wr_ctrl",       A_CTRL,        1'b1, 32'hFFFF_0201, 1'b1, 32'h0000_0001});
    vecs.push_back('{"rd_ctrl",       A_CTRL,        1'b0, 32'h0,         1'b1, 32'h0000_0201});
    vecs.push_back('{"wr_digits",     A_DIGITS,      1'b1, 32'hCAFE_BABE, 1'b0, 32'h0});
    vecs.push_back('{"rd_digits",     A_DIGITS,      1'b0, 32'h0,         1'b1, 32'hCAFE_BABE});

    // k = edge count from the re-enable store; expected display held over each span
    spans.push_back('{0,  3,  4'hF, 8'hFF});
    spans.push_back('{4,  7,  4'hE, 8'h8E});
    spans.push_back('{8,  11, 4'hD, 8'h86});
    spans.push_back('{12, 15, 4'hB, 8'h86});
    spans.push_back('{16, 19, 4'h7, 8'h83});
    spans.push_back('{20, 23, 4'hE, 8'h8E});
    spans.push_back('{24, 27, 4'hD, 8'h86});
    spans.push_back('{28, 31, 4'hB, 8'h86});
    spans.push_back('{32, 35, 4'h7, 8'h83});
    spans.push_back('{36, 39, 4'hE, 8'h8E});
    spans.push_back('{40, 43, 4'hD, 8'h06});
    spans.push_back('{44, 47, 4'hB, 8'h86});
    spans.push_back('{48, 51, 4'h7, 8'hF9});
    spans.push_back('{52, 55, 4'hE, 8'h99});
    spans.push_back('{56, 58, 4'hD, 8'h30});
    spans.push_back('{59, 66, 4'hF, 8'hFF});
    spans.push_back('{67, 70, 4'hE, 8'h99});
    spans.push_back('{71, 74, 4'hD, 8'hB0});
    spans.push_back('{75, 76, 4'hB, 8'hA4});

    writes.push_back('{0,  A_CTRL,   32'h0000_0001});
    writes.push_back('{24, A_CTRL,   32'h0000_0201});
    writes.push_back('{44, A_DIGITS, 32'h0000_1234});
    writes.push_back('{58, A_CTRL,   32'h0000_0000});
    writes.push_back('{63, A_CTRL,   32'h0000_0001});

    // Power-on reset
    #2 rst_n = 1'b0;
    #1;
    check("rst_an",   {28'h0, an}, 32'hF);
    check("rst_cath", {24'h0, cath}, 32'hFF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Load/store vector table
    foreach (vecs[i]) begin
      addr      = vecs[i].addr;
      wdata     = vecs[i].wdata;
      mem_write = vecs[i].we;
      mem_read  = vecs[i].re;
      rd_q.push_back(vecs[i].exp);
      #1;
      got = rd_q.pop_front();
      check(vecs[i].name, mem_data, got);
      $display("vec %-14s addr=%h we=%0b wdata=%h re=%0b data=%h", vecs[i].name,
               vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].re, mem_data);
      @(negedge clk);
    end
    mem_write = 1'b0;
    mem_read  = 1'b0;

    // Park the scanner disabled with BEEF loaded, then run the scripted scan
    store(A_CTRL, 32'h0);
    store(A_DIGITS, 32'h0000_BEEF);
    for (int k = 0; k <= 76; k++) begin
      mem_write = 1'b0;
      foreach (writes[w]) begin
        if (writes[w].k == k) begin
          addr      = writes[w].addr;
          wdata     = writes[w].data;
          mem_write = 1'b1;
        end
      end
      disp_q.push_back(exp_at(k));
      @(negedge clk);
      check_disp($sformatf("scan_k%0d", k));
    end
    mem_write = 1'b0;

    // Reset asserted while digit 2 is lit, checked before any clock edge
    rst_n = 1'b0;
    #1;
    check("midrst_an",   {28'h0, an}, 32'hF);
    check("midrst_cath", {24'h0, cath}, 32'hFF);
    mem_read = 1'b1;
    addr     = A_CTRL;
    #1 check("midrst_ctrl", mem_data, 32'h0000_0001);
    addr = A_DIGITS;
    #1 check("midrst_digits", mem_data, 32'h0);
    addr = 32'h0000_0008;
    #1 check("midrst_ram", mem_data, 32'h1234_5678);
    mem_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First tick after release lands on the 4th edge, showing digit 0 = '0'
    for (int k = 1; k <= 4; k++) begin
      d.an   = (k == 4) ? 4'hE : 4'hF;
      d.cath = (k == 4) ? 8'hC0 : 8'hFF;
      disp_q.push_back(d);
      @(negedge clk);
      check_disp($sformatf("first_tick_e%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
